// File: rtl/i2c_pkg.sv
// Shared register map, STATUS bit positions, FSM states and CTRL layout for the I2C APB controller.
package i2c_pkg;

  localparam int unsigned DATA_W = 8;

  localparam logic [7:0] REG_CTRL     = 8'h00;
  localparam logic [7:0] REG_ADDR     = 8'h04;
  localparam logic [7:0] REG_PRESCALE = 8'h08;
  localparam logic [7:0] REG_CMD      = 8'h0C;
  localparam logic [7:0] REG_TXDATA   = 8'h10;
  localparam logic [7:0] REG_RXDATA   = 8'h14;
  localparam logic [7:0] REG_STATUS   = 8'h18;
  localparam logic [7:0] REG_BYTECNT  = 8'h1C;

  localparam int unsigned STAT_BUSY     = 0;
  localparam int unsigned STAT_TX_FULL  = 1;
  localparam int unsigned STAT_TX_EMPTY = 2;
  localparam int unsigned STAT_RX_FULL  = 3;
  localparam int unsigned STAT_RX_EMPTY = 4;
  localparam int unsigned STAT_DONE     = 5;
  localparam int unsigned STAT_ACK_ERR  = 6;
  localparam int unsigned STAT_RX_OVF   = 7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  typedef struct packed {
    logic irq_en;
    logic rw;
    logic enable;
  } ctrl_t;

  // A programmed byte count of zero means a single byte.
  function automatic logic [2:0] eff_byte_cnt(input logic [2:0] cnt);
    return (cnt == 3'd0) ? 3'd1 : cnt;
  endfunction

endpackage

// File: rtl/i2c_sync_fifo.sv
// Single-clock FIFO with registered full/empty flags; a push while full is accepted only if a pop frees a slot.
module i2c_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_pop    = pop & ~empty;
  assign do_push   = push & (~full | do_pop);
  assign count_nxt = count + CW'(do_push) - CW'(do_pop);
  assign head      = mem[rd_ptr];

  // Storage array write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/i2c_apb_ctrl.sv
// APB register front-end for an I2C byte engine: config registers, TX/RX FIFOs, sticky status and start sequencing.
module i2c_apb_ctrl
  import i2c_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [7:0]  PRESCALE_RST = 8'h04
) (
  input  logic       apb_clk,
  input  logic       preset_n,
  input  logic [7:0] paddr,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       pslverr,
  output logic       core_start,
  input  logic       core_busy,
  input  logic       core_done,
  input  logic       core_ack_err,
  output logic [7:0] core_tx_data,
  output logic       core_tx_valid,
  input  logic       core_tx_pop,
  input  logic [7:0] core_rx_data,
  input  logic       core_rx_push,
  output logic       cfg_enable,
  output logic       cfg_rw,
  output logic [6:0] cfg_slave_addr,
  output logic [7:0] cfg_prescale,
  output logic [2:0] cfg_byte_cnt,
  output logic       irq
);

  state_t      state;
  state_t      state_nxt;
  logic        start_nxt;

  ctrl_t       ctrl;
  logic [6:0]  slave_addr;
  logic [7:0]  prescale;
  logic [2:0]  byte_cnt;
  logic        flag_done;
  logic        flag_ack_err;
  logic        flag_rx_ovf;
  logic        acc_seen;

  logic        tx_full;
  logic        tx_empty;
  logic        rx_full;
  logic        rx_empty;
  logic [7:0]  tx_head;
  logic [7:0]  rx_head;

  logic        setup_c;
  logic        access_c;
  logic        wr_ok_c;
  logic        rd_ok_c;
  logic        busy_c;
  logic        err_c;
  logic [7:0]  rd_data_c;
  logic [7:0]  status_c;
  logic        start_req_c;
  logic        tx_push_c;
  logic        rx_pop_c;
  logic        status_wr_c;
  logic        ovf_set_c;

  // Error and read data are decided in the setup phase and acted on in the access phase,
  // so a rejected access is never half-committed. acc_seen limits commits to one per transfer.
  assign setup_c  = psel & ~penable;
  assign access_c = psel & penable & ~acc_seen;
  assign wr_ok_c  = access_c & pwrite & ~pslverr;
  assign rd_ok_c  = access_c & ~pwrite & ~pslverr;
  assign busy_c   = (state != S_IDLE) | core_busy;

  assign start_req_c = wr_ok_c & (paddr == REG_CMD) & pwdata[0] & ctrl.enable;
  assign tx_push_c   = wr_ok_c & (paddr == REG_TXDATA);
  assign rx_pop_c    = rd_ok_c & (paddr == REG_RXDATA);
  assign status_wr_c = wr_ok_c & (paddr == REG_STATUS);
  assign ovf_set_c   = core_rx_push & rx_full & ~rx_pop_c;

  // STATUS register image.
  always_comb begin
    status_c                = '0;
    status_c[STAT_BUSY]     = busy_c;
    status_c[STAT_TX_FULL]  = tx_full;
    status_c[STAT_TX_EMPTY] = tx_empty;
    status_c[STAT_RX_FULL]  = rx_full;
    status_c[STAT_RX_EMPTY] = rx_empty;
    status_c[STAT_DONE]     = flag_done;
    status_c[STAT_ACK_ERR]  = flag_ack_err;
    status_c[STAT_RX_OVF]   = flag_rx_ovf;
  end

  // Address decode: read data and slave error for the transfer currently in setup.
  always_comb begin
    rd_data_c = '0;
    err_c     = 1'b0;
    case (paddr)
      REG_CTRL: begin
        rd_data_c = {5'd0, ctrl};
        err_c     = pwrite & busy_c;
      end
      REG_ADDR: begin
        rd_data_c = {1'b0, slave_addr};
        err_c     = pwrite & busy_c;
      end
      REG_PRESCALE: begin
        rd_data_c = prescale;
        err_c     = pwrite & busy_c;
      end
      REG_CMD: begin
        err_c = ~pwrite |
                (pwdata[0] & ctrl.enable & ((state != S_IDLE) | (~ctrl.rw & tx_empty)));
      end
      REG_TXDATA: begin
        err_c = ~pwrite | tx_full;
      end
      REG_RXDATA: begin
        err_c = pwrite | rx_empty;
        if (!rx_empty) rd_data_c = rx_head;
      end
      REG_STATUS: begin
        rd_data_c = status_c;
      end
      REG_BYTECNT: begin
        rd_data_c = {5'd0, byte_cnt};
        err_c     = pwrite & busy_c;
      end
      default: begin
        err_c = 1'b1;
      end
    endcase
    if (pwrite) rd_data_c = '0;
  end

  // APB response: capture in setup, hold through access, idle low otherwise.
  always_ff @(posedge apb_clk or negedge preset_n) begin
    if (!preset_n) begin
      prdata   <= '0;
      pslverr  <= 1'b0;
      acc_seen <= 1'b0;
    end else begin
      acc_seen <= psel & penable;
      if (setup_c) begin
        prdata  <= rd_data_c;
        pslverr <= err_c;
      end else if (!(psel & penable)) begin
        prdata  <= '0;
        pslverr <= 1'b0;
      end
    end
  end

  // Configuration registers.
  always_ff @(posedge apb_clk or negedge preset_n) begin
    if (!preset_n) begin
      ctrl       <= '0;
      slave_addr <= '0;
      prescale   <= PRESCALE_RST;
      byte_cnt   <= '0;
    end else if (wr_ok_c) begin
      case (paddr)
        REG_CTRL:     ctrl       <= ctrl_t'(pwdata[2:0]);
        REG_ADDR:     slave_addr <= pwdata[6:0];
        REG_PRESCALE: prescale   <= pwdata;
        REG_BYTECNT:  byte_cnt   <= pwdata[2:0];
        default: ;
      endcase
    end
  end

  // Sticky flags: a set event in the same cycle as a write-1-to-clear keeps the flag set.
  always_ff @(posedge apb_clk or negedge preset_n) begin
    if (!preset_n) begin
      flag_done    <= 1'b0;
      flag_ack_err <= 1'b0;
      flag_rx_ovf  <= 1'b0;
    end else begin
      flag_done    <= core_done | (flag_done & ~(status_wr_c & pwdata[STAT_DONE]));
      flag_ack_err <= (core_done & core_ack_err) |
                      (flag_ack_err & ~(status_wr_c & pwdata[STAT_ACK_ERR]));
      flag_rx_ovf  <= ovf_set_c | (flag_rx_ovf & ~(status_wr_c & pwdata[STAT_RX_OVF]));
    end
  end

  // FSM state register.
  always_ff @(posedge apb_clk or negedge preset_n) begin
    if (!preset_n) state <= S_IDLE;
    else           state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_req_c) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (core_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM output decode: start is high exactly while the FSM sits in ISSUE.
  always_comb begin
    start_nxt = 1'b0;
    if (state_nxt == S_ISSUE) start_nxt = 1'b1;
  end

  // Registered start pulse.
  always_ff @(posedge apb_clk or negedge preset_n) begin
    if (!preset_n) core_start <= 1'b0;
    else           core_start <= start_nxt;
  end

  i2c_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (apb_clk),
    .rst_n     (preset_n),
    .push      (tx_push_c),
    .push_data (pwdata),
    .pop       (core_tx_pop),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  i2c_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk       (apb_clk),
    .rst_n     (preset_n),
    .push      (core_rx_push),
    .push_data (core_rx_data),
    .pop       (rx_pop_c),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  assign pready         = psel & penable;
  assign core_tx_data   = tx_head;
  assign core_tx_valid  = ~tx_empty;
  assign cfg_enable     = ctrl.enable;
  assign cfg_rw         = ctrl.rw;
  assign cfg_slave_addr = slave_addr;
  assign cfg_prescale   = prescale;
  assign cfg_byte_cnt   = eff_byte_cnt(byte_cnt);
  assign irq            = ctrl.irq_en & (flag_done | flag_ack_err | flag_rx_ovf);

endmodule

// File: tb/tb_i2c_apb_ctrl.sv
// Directed bench for i2c_apb_ctrl: register table plus transfer, FIFO, interrupt and reset sequences.
module tb_i2c_apb_ctrl;

  logic       apb_clk;
  logic       preset_n;
  logic [7:0] paddr;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;
  logic       core_start;
  logic       core_busy;
  logic       core_done;
  logic       core_ack_err;
  logic [7:0] core_tx_data;
  logic       core_tx_valid;
  logic       core_tx_pop;
  logic [7:0] core_rx_data;
  logic       core_rx_push;
  logic       cfg_enable;
  logic       cfg_rw;
  logic [6:0] cfg_slave_addr;
  logic [7:0] cfg_prescale;
  logic [2:0] cfg_byte_cnt;
  logic       irq;

  int tests = 0;
  int fails = 0;
  int start_cnt = 0;

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    bit         err;
  } vec_t;

  localparam int NVEC = 29;
  vec_t vecs [NVEC];

  i2c_apb_ctrl #(
    .FIFO_DEPTH   (4),
    .PRESCALE_RST (8'h04)
  ) dut (
    .apb_clk        (apb_clk),
    .preset_n       (preset_n),
    .paddr          (paddr),
    .psel           (psel),
    .penable        (penable),
    .pwrite         (pwrite),
    .pwdata         (pwdata),
    .prdata         (prdata),
    .pready         (pready),
    .pslverr        (pslverr),
    .core_start     (core_start),
    .core_busy      (core_busy),
    .core_done      (core_done),
    .core_ack_err   (core_ack_err),
    .core_tx_data   (core_tx_data),
    .core_tx_valid  (core_tx_valid),
    .core_tx_pop    (core_tx_pop),
    .core_rx_data   (core_rx_data),
    .core_rx_push   (core_rx_push),
    .cfg_enable     (cfg_enable),
    .cfg_rw         (cfg_rw),
    .cfg_slave_addr (cfg_slave_addr),
    .cfg_prescale   (cfg_prescale),
    .cfg_byte_cnt   (cfg_byte_cnt),
    .irq            (irq)
  );

  initial apb_clk = 1'b0;
  always #5 apb_clk = ~apb_clk;

  // Count start pulses, one per cycle high.
  always @(posedge apb_clk) if (core_start) start_cnt <= start_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One APB transfer; checks pready, prdata at start and end of access, and pslverr.
  task automatic apb(input string n, input bit wr, input logic [7:0] a, input logic [7:0] d,
                     input logic [7:0] exp_r, input bit exp_e, input bit done_pulse);
    @(negedge apb_clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(negedge apb_clk);
    penable = 1'b1;
    if (done_pulse) core_done = 1'b1;
    #1;
    chk({n, "_pready"}, 32'(pready), 32'd1);
    chk({n, "_prdata0"}, 32'(prdata), 32'(exp_r));
    chk({n, "_pslverr"}, 32'(pslverr), 32'(exp_e));
    #3;
    chk({n, "_prdata1"}, 32'(prdata), 32'(exp_r));
    @(negedge apb_clk);
    psel = 1'b0; penable = 1'b0; core_done = 1'b0;
  endtask

  task automatic wr(input string n, input logic [7:0] a, input logic [7:0] d, input bit e);
    apb(n, 1'b1, a, d, 8'h00, e, 1'b0);
  endtask

  task automatic rd(input string n, input logic [7:0] a, input logic [7:0] exp, input bit e);
    apb(n, 1'b0, a, 8'h00, exp, e, 1'b0);
  endtask

  task automatic core_pop(input string n, input logic [7:0] exp);
    @(negedge apb_clk);
    chk({n, "_valid"}, 32'(core_tx_valid), 32'd1);
    chk({n, "_data"}, 32'(core_tx_data), 32'(exp));
    core_tx_pop = 1'b1;
    @(negedge apb_clk);
    core_tx_pop = 1'b0;
  endtask

  task automatic done_pulse(input bit ae);
    @(negedge apb_clk);
    core_done = 1'b1; core_ack_err = ae;
    @(negedge apb_clk);
    core_done = 1'b0; core_ack_err = 1'b0;
  endtask

  initial begin
    int sc;
    logic [7:0] rx_bytes [7];
    rx_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};

    vecs[0]  = '{1'b0, 8'h08, 8'h00, 8'h04, 1'b0};
    vecs[1]  = '{1'b0, 8'h18, 8'h00, 8'h14, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[3]  = '{1'b0, 8'h04, 8'h00, 8'h00, 1'b0};
    vecs[4]  = '{1'b0, 8'h1C, 8'h00, 8'h00, 1'b0};
    vecs[5]  = '{1'b0, 8'h0C, 8'h00, 8'h00, 1'b1};
    vecs[6]  = '{1'b0, 8'h10, 8'h00, 8'h00, 1'b1};
    vecs[7]  = '{1'b0, 8'h14, 8'h00, 8'h00, 1'b1};
    vecs[8]  = '{1'b1, 8'h14, 8'h77, 8'h00, 1'b1};
    vecs[9]  = '{1'b0, 8'h20, 8'h00, 8'h00, 1'b1};
    vecs[10] = '{1'b1, 8'h03, 8'hFF, 8'h00, 1'b1};
    vecs[11] = '{1'b1, 8'h04, 8'hD0, 8'h00, 1'b0};
    vecs[12] = '{1'b0, 8'h04, 8'h00, 8'h50, 1'b0};
    vecs[13] = '{1'b1, 8'h08, 8'h9C, 8'h00, 1'b0};
    vecs[14] = '{1'b0, 8'h08, 8'h00, 8'h9C, 1'b0};
    vecs[15] = '{1'b1, 8'h1C, 8'hFD, 8'h00, 1'b0};
    vecs[16] = '{1'b0, 8'h1C, 8'h00, 8'h05, 1'b0};
    vecs[17] = '{1'b1, 8'h0C, 8'h01, 8'h00, 1'b0};
    vecs[18] = '{1'b1, 8'h18, 8'hFF, 8'h00, 1'b0};
    vecs[19] = '{1'b0, 8'h18, 8'h00, 8'h14, 1'b0};
    vecs[20] = '{1'b1, 8'h00, 8'h02, 8'h00, 1'b0};
    vecs[21] = '{1'b0, 8'h00, 8'h00, 8'h02, 1'b0};
    vecs[22] = '{1'b1, 8'h00, 8'h01, 8'h00, 1'b0};
    vecs[23] = '{1'b1, 8'h0C, 8'h01, 8'h00, 1'b1};
    vecs[24] = '{1'b0, 8'h18, 8'h00, 8'h14, 1'b0};
    vecs[25] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[26] = '{1'b1, 8'h0C, 8'h00, 8'h00, 1'b0};
    vecs[27] = '{1'b0, 8'h18, 8'h00, 8'h14, 1'b0};
    vecs[28] = '{1'b0, 8'h01, 8'h00, 8'h00, 1'b1};

    preset_n = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    core_busy = 1'b0; core_done = 1'b0; core_ack_err = 1'b0;
    core_tx_pop = 1'b0; core_rx_data = '0; core_rx_push = 1'b0;
    repeat (3) @(negedge apb_clk);
    chk("rst_pslverr", 32'(pslverr), 32'd0);
    chk("rst_prdata", 32'(prdata), 32'd0);
    chk("rst_core_start", 32'(core_start), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    preset_n = 1'b1;

    // Register table.
    for (int i = 0; i < NVEC; i++) begin
      apb($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
          vecs[i].rdata, vecs[i].err, 1'b0);
    end
    chk("cfg_prescale", 32'(cfg_prescale), 32'h9C);
    chk("cfg_slave_addr", 32'(cfg_slave_addr), 32'h50);
    chk("cfg_byte_cnt", 32'(cfg_byte_cnt), 32'd5);
    chk("start_cnt_none", 32'(start_cnt), 32'd0);

    // External core_busy blocks config writes and shows in STATUS.
    core_busy = 1'b1;
    wr("cbusy_wr_presc", 8'h08, 8'h11, 1'b1);
    rd("cbusy_status", 8'h18, 8'h15, 1'b0);
    rd("cbusy_presc", 8'h08, 8'h9C, 1'b0);
    core_busy = 1'b0;

    // Write transfer: start pulse, WAIT-phase rejection, done.
    wr("a_addr", 8'h04, 8'h50, 1'b0);
    wr("a_ctrl", 8'h00, 8'h01, 1'b0);
    wr("a_tx", 8'h10, 8'hA5, 1'b0);
    chk("a_tx_valid", 32'(core_tx_valid), 32'd1);
    chk("a_tx_data", 32'(core_tx_data), 32'hA5);
    wr("a_cmd", 8'h0C, 8'h01, 1'b0);
    chk("a_start_hi", 32'(core_start), 32'd1);
    chk("a_cfg_addr", 32'(cfg_slave_addr), 32'h50);
    @(negedge apb_clk);
    chk("a_start_lo", 32'(core_start), 32'd0);
    rd("a_status_wait", 8'h18, 8'h11, 1'b0);
    wr("a_cmd_busy", 8'h0C, 8'h01, 1'b1);
    wr("a_ctrl_busy", 8'h00, 8'h00, 1'b1);
    rd("a_ctrl_kept", 8'h00, 8'h01, 1'b0);
    chk("a_enable_kept", 32'(cfg_enable), 32'd1);
    core_pop("a_pop", 8'hA5);
    done_pulse(1'b0);
    rd("a_status_done", 8'h18, 8'h34, 1'b0);
    chk("a_start_cnt", 32'(start_cnt), 32'd1);
    chk("a_irq_off", 32'(irq), 32'd0);
    wr("a_ctrl_off", 8'h00, 8'h00, 1'b0);
    chk("a_enable_off", 32'(cfg_enable), 32'd0);
    wr("a_clr_done", 8'h18, 8'h20, 1'b0);
    rd("a_status_clr", 8'h18, 8'h14, 1'b0);

    // TX FIFO overflow and ordering.
    for (int i = 1; i <= 4; i++) wr($sformatf("b_push%0d", i), 8'h10, 8'(i), 1'b0);
    wr("b_push5", 8'h10, 8'h55, 1'b1);
    rd("b_status_full", 8'h18, 8'h12, 1'b0);
    for (int i = 1; i <= 4; i++) core_pop($sformatf("b_pop%0d", i), 8'(i));
    @(negedge apb_clk);
    chk("b_tx_drained", 32'(core_tx_valid), 32'd0);

    // Read transfer with RX overflow and interrupts.
    wr("c_ctrl", 8'h00, 8'h07, 1'b0);
    chk("c_cfg_rw", 32'(cfg_rw), 32'd1);
    wr("c_cmd", 8'h0C, 8'h01, 1'b0);
    for (int i = 0; i < 7; i++) begin
      @(negedge apb_clk);
      core_rx_data = rx_bytes[i];
      core_rx_push = 1'b1;
    end
    @(negedge apb_clk);
    core_rx_push = 1'b0;
    chk("c_irq_ovf", 32'(irq), 32'd1);
    rd("c_status_ovf", 8'h18, 8'h8D, 1'b0);
    for (int i = 0; i < 4; i++) rd($sformatf("c_rx%0d", i), 8'h14, rx_bytes[i], 1'b0);
    rd("c_rx_empty", 8'h14, 8'h00, 1'b1);
    rd("c_status_drain", 8'h18, 8'h95, 1'b0);
    wr("c_clr_ovf", 8'h18, 8'h80, 1'b0);
    rd("c_status_clr", 8'h18, 8'h15, 1'b0);
    chk("c_irq_clr", 32'(irq), 32'd0);
    done_pulse(1'b1);
    rd("c_status_ackerr", 8'h18, 8'h74, 1'b0);
    chk("c_irq_done", 32'(irq), 32'd1);
    apb("c_clr_setwins", 1'b1, 8'h18, 8'h60, 8'h00, 1'b0, 1'b1);
    rd("c_status_setwins", 8'h18, 8'h34, 1'b0);
    wr("c_clr_done", 8'h18, 8'h20, 1'b0);
    rd("c_status_final", 8'h18, 8'h14, 1'b0);
    chk("c_irq_final", 32'(irq), 32'd0);

    // Reset in the middle of a transfer.
    wr("d_ctrl", 8'h00, 8'h01, 1'b0);
    wr("d_tx", 8'h10, 8'h3C, 1'b0);
    sc = start_cnt;
    wr("d_cmd", 8'h0C, 8'h01, 1'b0);
    @(negedge apb_clk);
    chk("d_bytecnt_pre", 32'(cfg_byte_cnt), 32'd5);
    preset_n = 1'b0;
    #1;
    chk("d_rst_start", 32'(core_start), 32'd0);
    chk("d_rst_enable", 32'(cfg_enable), 32'd0);
    chk("d_rst_addr", 32'(cfg_slave_addr), 32'h00);
    chk("d_rst_presc", 32'(cfg_prescale), 32'h04);
    chk("d_rst_bytecnt", 32'(cfg_byte_cnt), 32'd1);
    chk("d_rst_txvalid", 32'(core_tx_valid), 32'd0);
    chk("d_rst_prdata", 32'(prdata), 32'd0);
    chk("d_rst_pslverr", 32'(pslverr), 32'd0);
    chk("d_rst_irq", 32'(irq), 32'd0);
    @(negedge apb_clk);
    preset_n = 1'b1;
    #1;
    chk("d_post_start", 32'(core_start), 32'd0);
    rd("d_status", 8'h18, 8'h14, 1'b0);
    wr("d_ctrl2", 8'h00, 8'h01, 1'b0);
    wr("d_tx2", 8'h10, 8'h5A, 1'b0);
    wr("d_cmd2", 8'h0C, 8'h01, 1'b0);
    chk("d_start2", 32'(core_start), 32'd1);
    chk("d_tx_data2", 32'(core_tx_data), 32'h5A);
    core_pop("d_pop", 8'h5A);
    done_pulse(1'b0);
    rd("d_status_done", 8'h18, 8'h34, 1'b0);
    chk("d_start_cnt", 32'(start_cnt - sc), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
